// File: rtl/alu_op_sequencer.sv
// Command sequencer for a combinational 16-bit ALU: latches operands, waits SETTLE cycles, captures result/error.
// Optional build macro ALU_ERR_HOLD_EN: when defined, the accumulator is not updated by a capture that reports an error.
module alu_op_sequencer #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic             cmd_use_acc,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic [1:0]       alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [1:0]       rsp_error,
    output logic [31:0]      acc,
    output logic [1:0]       err_sticky,
    input  logic             err_clear,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE_WAIT = 2'd1,
        RESP        = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [3:0]         wait_cnt_r;
    logic               cmd_ready_r;
    logic               busy_r;
    logic               rsp_valid_r;
    logic               cmd_ready_next_s;
    logic               busy_next_s;
    logic               rsp_valid_next_s;
    logic [15:0]        alu_a_r;
    logic [15:0]        alu_b_r;
    logic [3:0]         alu_op_r;
    logic [31:0]        rsp_result_r;
    logic [1:0]         rsp_error_r;
    logic [31:0]        acc_r;
    logic [1:0]         err_sticky_r;
    logic [1:0]         err_sticky_next_s;
    logic [CNT_W-1:0]   op_count_r;
    logic               accept_s;
    logic               capture_s;
    logic               rsp_hs_s;
    logic               acc_load_s;

    assign accept_s  = (state_r == IDLE) && cmd_valid;
    assign capture_s = (state_r == SETTLE_WAIT) && (wait_cnt_r == 4'd0);
    assign rsp_hs_s  = (state_r == RESP) && rsp_ready;

`ifdef ALU_ERR_HOLD_EN
    assign acc_load_s = capture_s && (alu_error == 2'b00);
`else
    assign acc_load_s = capture_s;
`endif

    // A capture on the same edge as a clear still records its new error bits.
    assign err_sticky_next_s = (err_clear ? 2'b00 : err_sticky_r) | (capture_s ? alu_error : 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:        state_next_s = cmd_valid ? SETTLE_WAIT : IDLE;
            SETTLE_WAIT: state_next_s = (wait_cnt_r == 4'd0) ? RESP : SETTLE_WAIT;
            RESP:        state_next_s = rsp_ready ? IDLE : RESP;
            default:     state_next_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they can be registered without lag
    always_comb begin
        cmd_ready_next_s = 1'b0;
        busy_next_s      = 1'b1;
        rsp_valid_next_s = 1'b0;
        case (state_next_s)
            IDLE: begin
                cmd_ready_next_s = 1'b1;
                busy_next_s      = 1'b0;
            end
            SETTLE_WAIT: begin
                busy_next_s      = 1'b1;
            end
            RESP: begin
                rsp_valid_next_s = 1'b1;
            end
            default: begin
                cmd_ready_next_s = 1'b0;
                busy_next_s      = 1'b1;
                rsp_valid_next_s = 1'b0;
            end
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            cmd_ready_r <= cmd_ready_next_s;
            busy_r      <= busy_next_s;
            rsp_valid_r <= rsp_valid_next_s;
        end
    end

    // Operand latch, settle counter, result capture, accumulator, error flags and op counter
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r      <= 16'd0;
            alu_b_r      <= 16'd0;
            alu_op_r     <= 4'd0;
            wait_cnt_r   <= 4'd0;
            rsp_result_r <= 32'd0;
            rsp_error_r  <= 2'b00;
            acc_r        <= 32'd0;
            err_sticky_r <= 2'b00;
            op_count_r   <= '0;
        end else begin
            if (accept_s) begin
                alu_op_r   <= cmd_op;
                alu_b_r    <= cmd_b;
                alu_a_r    <= cmd_use_acc ? acc_r[15:0] : cmd_a;
                wait_cnt_r <= SETTLE_LOAD;
            end else if ((state_r == SETTLE_WAIT) && (wait_cnt_r != 4'd0)) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end
            if (capture_s) begin
                rsp_result_r <= alu_result;
                rsp_error_r  <= alu_error;
            end
            if (acc_load_s) begin
                acc_r <= alu_result;
            end
            err_sticky_r <= err_sticky_next_s;
            if (rsp_hs_s) begin
                op_count_r <= op_count_r + CNT_W'(1);
            end
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign busy       = busy_r;
    assign rsp_valid  = rsp_valid_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_op     = alu_op_r;
    assign rsp_result = rsp_result_r;
    assign rsp_error  = rsp_error_r;
    assign acc        = acc_r;
    assign err_sticky = err_sticky_r;
    assign op_count   = op_count_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a behavioural ALU closes the loop, a command table drives it,
// and a scoreboard queue holds the expected response of each accepted command.
module tb_alu_op_sequencer;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [15:0]      cmd_a;
    logic [15:0]      cmd_b;
    logic             cmd_use_acc;
    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic [3:0]       alu_op;
    logic [31:0]      alu_result;
    logic [1:0]       alu_error;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [1:0]       rsp_error;
    logic [31:0]      acc;
    logic [1:0]       err_sticky;
    logic             err_clear;
    logic [CNT_W-1:0] op_count;
    logic             busy;

    alu_op_sequencer #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .acc(acc), .err_sticky(err_sticky), .err_clear(err_clear),
        .op_count(op_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic [31:0] r;
        logic [1:0]  e;
        s = 16'd0;
        r = 32'd0;
        e = 2'b00;
        case (op)
            4'd0: begin s = a + b; r = {16'd0, s}; e[0] = (a[15] == b[15]) && (s[15] != a[15]); end
            4'd1: begin s = a - b; r = {16'd0, s}; e[0] = (a[15] != b[15]) && (s[15] != a[15]); end
            4'd2: r = 32'(a) * 32'(b);
            4'd3: if (b == 16'd0) e[1] = 1'b1; else r = {16'd0, a / b};
            4'd4: if (b == 16'd0) e[1] = 1'b1; else r = {16'd0, a % b};
            4'd5: r = {16'd0, a & b};
            4'd6: r = {16'd0, a | b};
            4'd7: r = {16'd0, a ^ b};
            4'd8: r = {16'd0, ~(a & b)};
            4'd9: r = {16'd0, ~(a | b)};
            4'd10: r = {16'd0, ~(a ^ b)};
            4'd11: r = {16'd0, ~a};
            4'd14: r = 32'hFFFF_FFFF;
            default: r = 32'd0;
        endcase
        return {e, r};
    endfunction

    always_comb {alu_error, alu_result} = alu_model(alu_op, alu_a, alu_b);

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        use_acc;
        logic [31:0] res;
        logic [1:0]  err;
        int          delay;
        logic        clr_during;
        logic        clr_after;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  err;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        tbl[13];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_acc = 32'd0;
    logic [1:0]  exp_sticky = 2'b00;
    logic [15:0] exp_count = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send_cmd(input vec_t v);
        int   t;
        logic [15:0] exp_a;
        exp_t e;
        cmd_valid   = 1'b1;
        cmd_op      = v.op;
        cmd_a       = v.a;
        cmd_b       = v.b;
        cmd_use_acc = v.use_acc;
        err_clear   = v.clr_during;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("cmd_ready_timeout", 32'(t < 20), 32'd1);
        exp_a = v.use_acc ? exp_acc[15:0] : v.a;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        sb_q.push_back('{res: v.res, err: v.err});
        check("alu_a", alu_a, exp_a);
        check("alu_b", alu_b, v.b);
        check("alu_op", alu_op, v.op);
        check("busy_after_accept", busy, 1'b1);
        check("cmd_ready_after_accept", cmd_ready, 1'b0);
        for (int i = 1; i < SETTLE; i++) begin
            @(posedge clk); #1;
            check("rsp_valid_early", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        check("rsp_valid_latency", rsp_valid, 1'b1);
`ifdef ALU_ERR_HOLD_EN
        if (v.err == 2'b00) exp_acc = v.res;
`else
        exp_acc = v.res;
`endif
        if (v.clr_during) exp_sticky = 2'b00;
        exp_sticky = exp_sticky | v.err;
        err_clear = 1'b0;
        check("acc", acc, exp_acc);
        check("err_sticky", err_sticky, exp_sticky);
        rsp_ready = (v.delay == 0);
        for (int i = 0; i < v.delay; i++) begin
            cmd_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_result", rsp_result, v.res);
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("rsp_result", rsp_result, e.res);
            check("rsp_error", rsp_error, e.err);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        exp_count++;
        check("rsp_valid_after_hs", rsp_valid, 1'b0);
        check("op_count", op_count, exp_count);
        check("cmd_ready_after_hs", cmd_ready, 1'b1);
        check("busy_after_hs", busy, 1'b0);
        if (v.clr_after) begin
            err_clear = 1'b1;
            @(posedge clk); #1;
            err_clear = 1'b0;
            exp_sticky = 2'b00;
            check("err_clear", err_sticky, exp_sticky);
        end
    endtask

    initial begin
        vec_t post;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 4'd0;
        cmd_a       = 16'd0;
        cmd_b       = 16'd0;
        cmd_use_acc = 1'b0;
        rsp_ready   = 1'b1;
        err_clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_acc", acc, 32'd0);
        check("rst_op_count", op_count, 32'd0);
        check("rst_err_sticky", err_sticky, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);

        //                op     a          b         ua    res             err    dly clrd  clra
        tbl[0]  = '{4'd0,  16'd15,    16'd126,  1'b0, 32'd141,        2'b00, 0, 1'b0, 1'b0};
        tbl[1]  = '{4'd0,  16'hFFFF,  16'd9,    1'b1, 32'd150,        2'b00, 0, 1'b0, 1'b0};
        tbl[2]  = '{4'd1,  16'd15,    16'd126,  1'b0, 32'h0000_FF91,  2'b00, 0, 1'b0, 1'b0};
        tbl[3]  = '{4'd2,  16'd15,    16'd126,  1'b0, 32'd1890,       2'b00, 0, 1'b0, 1'b0};
        tbl[4]  = '{4'd3,  16'd100,   16'd0,    1'b0, 32'd0,          2'b10, 0, 1'b0, 1'b1};
        tbl[5]  = '{4'd5,  16'hF0F0,  16'hFF00, 1'b0, 32'h0000_F000,  2'b00, 5, 1'b0, 1'b0};
        tbl[6]  = '{4'd0,  16'h7FFF,  16'd1,    1'b0, 32'h0000_8000,  2'b01, 0, 1'b0, 1'b0};
        tbl[7]  = '{4'd4,  16'd100,   16'd7,    1'b0, 32'd2,          2'b00, 0, 1'b0, 1'b0};
        tbl[8]  = '{4'd2,  16'hFFFF,  16'd50,   1'b1, 32'd100,        2'b00, 0, 1'b0, 1'b0};
        tbl[9]  = '{4'd12, 16'd5,     16'd5,    1'b0, 32'd0,          2'b00, 0, 1'b0, 1'b0};
        tbl[10] = '{4'd3,  16'd1000,  16'd0,    1'b0, 32'd0,          2'b10, 0, 1'b1, 1'b0};
        tbl[11] = '{4'd3,  16'd1000,  16'd3,    1'b0, 32'd333,        2'b00, 0, 1'b0, 1'b0};
        tbl[12] = '{4'd1,  16'd0,     16'd1,    1'b0, 32'h0000_FFFF,  2'b00, 0, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            send_cmd(tbl[i]);
        end

        // Reset while the ALU inputs are settling: the command must vanish without a response.
        cmd_valid = 1'b1;
        cmd_op    = 4'd0;
        cmd_a     = 16'd1;
        cmd_b     = 16'd1;
        cmd_use_acc = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mid_rst_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_acc    = 32'd0;
        exp_sticky = 2'b00;
        exp_count  = 16'd0;
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_acc", acc, exp_acc);
        check("mid_rst_op_count", op_count, exp_count);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("dropped_no_rsp", rsp_valid, 1'b0);
        end

        post = '{4'd0, 16'd2, 16'd3, 1'b0, 32'd5, 2'b00, 0, 1'b0, 1'b0};
        send_cmd(post);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-driven controller that sequences the combinational 16-bit ALU datapath (add/sub/mul/div/mod/logic, 4-bit opcode, 32-bit result, 2-bit error).
- Accepts one command at a time over a valid/ready handshake and drives the ALU operand/opcode inputs from registers.
- Waits a fixed settle time, then captures the result into a response register and a 32-bit accumulator.
- Keeps sticky error flags and a completed-operation counter; sits between the instruction source and the ALU.

Parameters:
SETTLE, 2, cycles the ALU inputs are held stable before capture (legal range 1..15)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  4  ALU opcode (0 add, 1 sub, 2 mul, 3 div, 4 mod, 5-11 logic, 14 preset, 15 reset)
cmd_a  input  16  operand A
cmd_b  input  16  operand B
cmd_use_acc  input  1  1: ALU A operand = acc[15:0] instead of cmd_a
alu_a  output  16  ALU operand A (registered)
alu_b  output  16  ALU operand B (registered)
alu_op  output  4  ALU opcode (registered)
alu_result  input  32  ALU result
alu_error  input  2  ALU error ([0] add/sub overflow, [1] div/mod by zero)
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_result  output  32  captured result
rsp_error  output  2  captured error
acc  output  32  accumulator
err_sticky  output  2  OR of all captured errors since reset/clear
err_clear  input  1  clear err_sticky
op_count  output  CNT_W  number of completed response handshakes
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous): state IDLE, cmd_ready=1, rsp_valid=0, and the following are 0: alu_a, alu_b, alu_op, rsp_result, rsp_error, acc, err_sticky, op_count, wait counter.
- rst has priority over every other input; reset mid-operation drops the in-flight command with no response.
- States: IDLE, SETTLE_WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge k, register alu_op=cmd_op, alu_b=cmd_b, and alu_a=(cmd_use_acc ? acc[15:0] : cmd_a).
  - Load wait counter with SETTLE-1 and go to SETTLE_WAIT.
- SETTLE_WAIT:
  - cmd_ready=0; alu_* held constant; counter decrements each cycle.
  - At counter==0, on edge k+SETTLE, capture rsp_result=alu_result and rsp_error=alu_error.
  - Same edge: update acc (see Optional Feature), set err_sticky |= alu_error, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_result and rsp_error stable until accepted.
  - On rsp_valid&rsp_ready: rsp_valid=0, op_count+1 (wraps max->0), return to IDLE.
  - cmd_ready rises the cycle after the response handshake; no command overlap.
- Minimum command-to-command period: SETTLE+2 cycles with rsp_ready tied high.
- cmd_use_acc uses acc as it stands at the accept edge.
- Opcodes 12/13: pass the ALU result (0) through; no special handling.
- err_clear: clears err_sticky on the next edge. If a capture occurs on the same edge, the new alu_error bits are set (set wins over clear).
- alu_a/alu_b/alu_op keep their last values while in RESP and IDLE; they change only on command accept.

Optional Feature:
ALU_ERR_HOLD_EN
- Defined: acc is not updated when captured alu_error!=0; rsp_result still shows the raw ALU result.
- Undefined: acc=alu_result on every capture, regardless of error.

Test Plan:
- Reset, then cmd op=0, a=15, b=126, SETTLE=2, rsp_ready=1 -> rsp_valid rises exactly 2 cycles after accept edge; rsp_result=141, rsp_error=00, acc=141, op_count=1.
- op=1, a=15, b=126 -> rsp_result=0x0000FF91, rsp_error=00; then op=2, a=15, b=126 -> rsp_result=1890.
- acc=141, cmd_use_acc=1, op=0, cmd_a=0xFFFF, b=9 -> alu_a=141, rsp_result=150, acc=150.
- op=3, a=100, b=0 -> rsp_result=0, rsp_error=10, err_sticky=10; acc unchanged with ALU_ERR_HOLD_EN, acc=0 without. Then err_clear for 1 cycle -> err_sticky=00.
- Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_result stable, cmd_ready=0 throughout; rsp_ready=1 -> next command accepted one cycle later.
- Assert rst during SETTLE_WAIT -> next cycle state IDLE, rsp_valid=0, acc=0, op_count=0; no response ever appears for the dropped command.
